// File: rtl/bp_me_wb_arbiter.sv
// Purpose: round-robin owner of a shared Wishbone B4 slave bus for num_masters_p masters.
// Latency: 1 cycle request-to-cyc_o (registered grant), then zero-latency mux of fields/acks.
// Backpressure: non-granted masters see ack=0 and stall; granted master stalls on slave ack_i.
//
// Ports: clk_i/reset_i (async active-high); m_* = packed per-master WB request fields
// (master i at slice i), m_ack_o/m_err_o per master, m_dat_o broadcast of dat_i;
// cyc_o..bte_o/dat_i/ack_i = single shared slave port.
// Optional: define BP_ME_WB_ARBITER_TIMEOUT_EN for the ack watchdog (m_err_o pulse).
module bp_me_wb_arbiter #(
  parameter int num_masters_p    = 2,
  parameter int adr_width_p      = 37,
  parameter int data_width_p     = 64,
  parameter int timeout_cycles_p = 256
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_masters_p-1:0]                 m_cyc_i,
  input  logic [num_masters_p-1:0]                 m_stb_i,
  input  logic [num_masters_p-1:0]                 m_we_i,
  input  logic [num_masters_p*adr_width_p-1:0]     m_adr_i,
  input  logic [num_masters_p*data_width_p-1:0]    m_dat_i,
  input  logic [num_masters_p*(data_width_p/8)-1:0] m_sel_i,
  input  logic [num_masters_p*3-1:0]               m_cti_i,
  input  logic [num_masters_p*2-1:0]               m_bte_i,
  output logic [num_masters_p-1:0]                 m_ack_o,
  output logic [num_masters_p-1:0]                 m_err_o,
  output logic [data_width_p-1:0]                  m_dat_o,
  output logic                                     cyc_o,
  output logic                                     stb_o,
  output logic                                     we_o,
  output logic [adr_width_p-1:0]                   adr_o,
  output logic [data_width_p-1:0]                  dat_o,
  output logic [data_width_p/8-1:0]                sel_o,
  output logic [2:0]                               cti_o,
  output logic [1:0]                               bte_o,
  input  logic [data_width_p-1:0]                  dat_i,
  input  logic                                     ack_i
);

  localparam int sel_width_lp   = data_width_p / 8;
  localparam int grant_width_lp = (num_masters_p > 1) ? $clog2(num_masters_p) : 1;

  typedef enum logic {e_idle, e_busy} state_e;

  state_e                    state_q, state_n;
  logic [grant_width_lp-1:0] grant_q, grant_n, rr_q, rr_n, winner;
  logic                      winner_vld;
  int                        arb_idx;

  logic                      busy, ack_fwd, end_of_cycle, rel_tenure, timeout_hit;
  logic                      sel_cyc, sel_stb, sel_we;
  logic [adr_width_p-1:0]    sel_adr;
  logic [data_width_p-1:0]   sel_dat;
  logic [sel_width_lp-1:0]   sel_sel;
  logic [2:0]                sel_cti;
  logic [1:0]                sel_bte;

  // Round-robin pick: scan starting just after the last winner so the
  // releasing master is always considered last.
  always_comb begin
    winner_vld = 1'b0;
    winner     = '0;
    arb_idx    = 0;
    for (int i = 1; i <= num_masters_p; i++) begin
      arb_idx = (int'(rr_q) + i) % num_masters_p;
      if (!winner_vld && m_cyc_i[arb_idx]) begin
        winner_vld = 1'b1;
        winner     = grant_width_lp'(arb_idx);
      end
    end
  end

  // Field mux of the granted master.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_adr = '0;
    sel_dat = '0;
    sel_sel = '0;
    sel_cti = '0;
    sel_bte = '0;
    for (int i = 0; i < num_masters_p; i++) begin
      if (grant_q == grant_width_lp'(i)) begin
        sel_cyc = m_cyc_i[i];
        sel_stb = m_stb_i[i];
        sel_we  = m_we_i[i];
        sel_adr = m_adr_i[i*adr_width_p +: adr_width_p];
        sel_dat = m_dat_i[i*data_width_p +: data_width_p];
        sel_sel = m_sel_i[i*sel_width_lp +: sel_width_lp];
        sel_cti = m_cti_i[i*3 +: 3];
        sel_bte = m_bte_i[i*2 +: 2];
      end
    end
  end

  assign busy  = (state_q == e_busy);
  // A timeout kills the handshake in the same cycle the error is reported.
  assign cyc_o = busy & sel_cyc & ~timeout_hit;
  assign stb_o = cyc_o & sel_stb;
  assign we_o  = busy & sel_we;
  assign adr_o = busy ? sel_adr : '0;
  assign dat_o = busy ? sel_dat : '0;
  assign sel_o = busy ? sel_sel : '0;
  assign cti_o = busy ? sel_cti : '0;
  assign bte_o = busy ? sel_bte : '0;

  assign m_dat_o = dat_i;

  // Acks outside an active strobe are stray and never reach a master.
  assign ack_fwd      = ack_i & cyc_o & stb_o;
  assign end_of_cycle = (sel_cti == 3'b000) || (sel_cti == 3'b111);
  assign rel_tenure   = busy & (~sel_cyc | (ack_fwd & end_of_cycle) | timeout_hit);

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    for (int i = 0; i < num_masters_p; i++) begin
      if (grant_q == grant_width_lp'(i)) begin
        m_ack_o[i] = ack_fwd;
        m_err_o[i] = timeout_hit;
      end
    end
  end

`ifdef BP_ME_WB_ARBITER_TIMEOUT_EN
  localparam int tcnt_width_lp = $clog2(timeout_cycles_p) + 1;
  logic [tcnt_width_lp-1:0] tcnt_q;

  // Counter value equals the number of stalled cycles already seen, so the
  // hit lands on the timeout_cycles_p-th stalled cycle. A same-cycle ack wins.
  assign timeout_hit = busy & sel_cyc & sel_stb & ~ack_i
                     & (tcnt_q == tcnt_width_lp'(timeout_cycles_p - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                tcnt_q <= '0;
    else if (!busy || ack_fwd)  tcnt_q <= '0;
    else if (cyc_o && stb_o)    tcnt_q <= tcnt_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    rr_n    = rr_q;
    case (state_q)
      e_idle: if (winner_vld) begin
        grant_n = winner;
        rr_n    = winner;
        state_n = e_busy;
      end
      e_busy: if (rel_tenure) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      grant_q <= '0;
      rr_q    <= grant_width_lp'(num_masters_p - 1);
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      rr_q    <= rr_n;
    end
  end

endmodule

// File: tb/tb_bp_me_wb_arbiter.sv
// Purpose: directed self-checking bench for bp_me_wb_arbiter (2 masters).
// Latency: inputs driven on negedge, outputs sampled 1ns later, state moves on posedge.
// Backpressure: slave acks are scripted per cycle; masters hold requests until acked.
module tb_bp_me_wb_arbiter;

  localparam int nm_lp = 2;
  localparam int aw_lp = 16;
  localparam int dw_lp = 32;
  localparam int sw_lp = dw_lp / 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [nm_lp-1:0]       m_cyc, m_stb, m_we;
  logic [nm_lp*aw_lp-1:0] m_adr;
  logic [nm_lp*dw_lp-1:0] m_dat;
  logic [nm_lp*sw_lp-1:0] m_sel;
  logic [nm_lp*3-1:0]     m_cti;
  logic [nm_lp*2-1:0]     m_bte;
  logic [nm_lp-1:0]       m_ack, m_err;
  logic [dw_lp-1:0]       m_dat_rd;
  logic                   cyc, stb, we;
  logic [aw_lp-1:0]       adr;
  logic [dw_lp-1:0]       dat_wr, dat_rd;
  logic [sw_lp-1:0]       sel;
  logic [2:0]             cti;
  logic [1:0]             bte;
  logic                   ack;

  int n_cmp = 0;
  int n_err = 0;

  bp_me_wb_arbiter #(
    .num_masters_p(nm_lp), .adr_width_p(aw_lp), .data_width_p(dw_lp), .timeout_cycles_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_sel_i(m_sel), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dat_rd),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_wr), .sel_o(sel),
    .cti_o(cti), .bte_o(bte), .dat_i(dat_rd), .ack_i(ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    logic [1:0]  exp_err;
    logic        exp_cyc;
    logic [15:0] exp_adr;

    reset = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = {16'h0222, 16'h0010};
    m_dat = {32'h1234_5678, 32'h0};
    m_sel = {4'hF, 4'h0};
    m_cti = '0; m_bte = '0;
    ack = 1'b0; dat_rd = '0;

    #3;
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_ack", m_ack, 0);
    check("rst_err", m_err, 0);
    @(negedge clk); reset = 1'b0;

    // 1: M0 classic read, ack on the third bus cycle
    @(negedge clk); m_cyc = 2'b01; m_stb = 2'b01; #1;
    check("t1_arb_latency", cyc, 0);
    @(negedge clk); #1;
    check("t1_cyc", cyc, 1);
    check("t1_stb", stb, 1);
    check("t1_adr", adr, 16'h0010);
    check("t1_no_ack_yet", m_ack, 0);
    @(negedge clk); #1;
    check("t1_wait", m_ack, 0);
    @(negedge clk); ack = 1'b1; dat_rd = 32'hCAFE_F00D; #1;
    check("t1_ack", m_ack, 2'b01);
    check("t1_rdata", m_dat_rd, 32'hCAFE_F00D);
    @(negedge clk); ack = 1'b0; m_cyc = '0; m_stb = '0; #1;
    check("t1_idle", cyc, 0);
    check("t1_ack_clr", m_ack, 0);

    // 2: simultaneous requests from reset alternate 0,1,0,1
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; #1;
    check("t2_arb_latency", cyc, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); ack = 1'b1; #1;
      check("t2_grant", m_ack, (k % 2) ? 2'b10 : 2'b01);
      check("t2_adr", adr, (k % 2) ? 16'h0222 : 16'h0010);
      @(negedge clk); ack = 1'b0;
      if (k == 3) begin m_cyc = '0; m_stb = '0; end
      #1;
      check("t2_dead_cycle", cyc, 0);
    end

    // 3: M1 4-beat wrap write burst while M0 waits
    @(negedge clk);
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
    m_cti = {3'b010, 3'b000}; m_bte = {2'b01, 2'b00}; #1;
    check("t3_arb_latency", cyc, 0);
    @(negedge clk); m_cyc = 2'b11; m_stb = 2'b11; #1;
    check("t3_adr", adr, 16'h0222);
    check("t3_bte", bte, 2'b01);
    check("t3_we", we, 1);
    check("t3_wdata", dat_wr, 32'h1234_5678);
    check("t3_sel", sel, 4'hF);
    check("t3_no_ack", m_ack, 0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); ack = 1'b1; m_cti[5:3] = (b == 3) ? 3'b111 : 3'b010; #1;
      check("t3_beat_ack", m_ack, 2'b10);
      check("t3_beat_cti", cti, (b == 3) ? 3'b111 : 3'b010);
    end
    @(negedge clk); ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01; m_we = '0; m_cti = '0; #1;
    check("t3_dead_cycle", cyc, 0);

    // 4: M0 starts a burst, drops cyc after one ack, M1 then gets the bus
    @(negedge clk); m_cti[2:0] = 3'b010; m_cyc = 2'b11; m_stb = 2'b11; ack = 1'b1; #1;
    check("t4_m0_after_burst", m_ack, 2'b01);
    check("t4_m0_adr", adr, 16'h0010);
    @(negedge clk); ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10; #1;
    check("t4_drop_cyc", cyc, 0);
    @(negedge clk); #1;
    check("t4_dead_cycle", cyc, 0);
    @(negedge clk); #1;
    check("t4_m1_cyc", cyc, 1);
    check("t4_m1_adr", adr, 16'h0222);

    // 5: async reset mid-transfer
    m_cyc = 2'b11; m_stb = 2'b11; m_cti = '0;
    #1; ack = 1'b1; reset = 1'b1; #1;
    check("t5_rst_cyc", cyc, 0);
    check("t5_rst_stb", stb, 0);
    check("t5_rst_ack", m_ack, 0);
    @(negedge clk); reset = 1'b0; ack = 1'b0; #1;
    check("t5_arb_latency", cyc, 0);
    @(negedge clk); ack = 1'b1; #1;
    check("t5_m0_first", m_ack, 2'b01);

    // 6: M1 granted, slave never acks
    @(negedge clk); ack = 1'b0; #1;
    check("t6_dead_cycle", cyc, 0);
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk); #1;
`ifdef BP_ME_WB_ARBITER_TIMEOUT_EN
      exp_cyc = (s <= 7) || (s == 10);
      exp_err = (s == 8) ? 2'b10 : 2'b00;
      exp_adr = 16'h0010;
`else
      exp_cyc = 1'b1;
      exp_err = 2'b00;
      exp_adr = 16'h0222;
`endif
      check("t6_cyc", cyc, exp_cyc);
      check("t6_err", m_err, exp_err);
      if (s == 10) check("t6_owner", adr, exp_adr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
